// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: valid/ready handshake, 2-entry skid with registered ready,
// hold/flush and NOP on empty. Optional perf counters under PIPE_STAGE_BUF_PERF_EN.
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}},
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              hold,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic              main_valid, skid_valid, ready_q;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              main_valid_n, skid_valid_n;
  logic [DATA_W-1:0] main_data_n, skid_data_n;
  logic              push, pop;

  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  assign in_ready  = ready_q;
  assign out_valid = main_valid & ~hold;
  assign out_data  = main_valid ? main_data : NOP_DATA;
  assign push      = in_valid & ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    main_valid_n = main_valid;
    skid_valid_n = skid_valid;
    main_data_n  = main_data;
    skid_data_n  = skid_data;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else begin
      case (occupancy)
        2'd0: if (push) begin
          main_valid_n = 1'b1;
          main_data_n  = in_data;
        end
        2'd1: begin
          if (push && pop) begin
            main_data_n = in_data;
          end else if (push) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
          end else if (pop) begin
            main_valid_n = 1'b0;
          end
        end
        default: if (pop) begin
          main_data_n  = skid_data;
          skid_valid_n = 1'b0;
        end
      endcase
    end
  end

  // ready is registered from next occupancy so out_ready never reaches in_ready combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      ready_q    <= ~(main_valid_n & skid_valid_n);
    end
  end

  // payload regs are not reset; valid bits gate them
  always_ff @(posedge clk) begin
    main_data <= main_data_n;
    skid_data <= skid_data_n;
  end

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_ev, flush_ev;
  assign stall_ev = (main_valid & ~pop) | (in_valid & ~ready_q);
  assign flush_ev = flush & (occupancy != 2'd0);
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_ev && stall_q != {CNT_W{1'b1}}) stall_q <= stall_q + 1'b1;
      if (flush_ev && flush_q != {CNT_W{1'b1}}) flush_q <= flush_q + 1'b1;
    end
  end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule
